execute_mdu: RTL
================

Name: execute_mdu

Overview:
Next-generation RV32 execute stage. It keeps the single-cycle RV32I ALU, branch, jump, load and store handling. It adds full RV32I ALU coverage (OR/XOR/shift/SLT families), byte/half stores (SB/SH), and the RV32M multiply/divide group on a parametrised iterative unit. An inst_vld/inst_rdy handshake and a flush input let the stage stall decode while a multi-cycle op runs, and let the op be killed on a redirect. It sits between decode and the memory/writeback stage; its output ports keep the existing EX_* contract.

Parameters:
ID_W, `InstIDDepth, width of instID.
FAST_MUL, 0, 1: MUL/MULH/MULHSU/MULHU complete in one cycle (combinational product); 0: iterative shift-add, 32 iterations.
DIV_STEP, 1, quotient bits resolved per iteration (legal values 1 or 2); divide takes 32/DIV_STEP iterations.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
inst_vld  in  1  decode presents an instruction.
inst_rdy  out  1  stage can accept; transfer occurs when inst_vld & inst_rdy.
flush  in  1  kill in-flight MDU op and any instruction offered this cycle.
x_rs1, x_rs2  in  32  source operands.
imm  in  32  decoded immediate.
instID  in  ID_W  instruction ID (`ID_* from defines.v, extended with ID_OR/ORI/XOR/XORI/SLL/SLLI/SRL/SRLI/SRA/SRAI/SLT/SLTI/SLTU/SLTIU/SB/SH/MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
pc  in  32  instruction PC.
EX_jmp_vld  out  1  branch/JALR taken pulse.
EX_jmp_addr  out  32  jump target.
EX_x_rd_vld  out  1  rd write pulse.
EX_x_rd  out  32  rd value.
EX_MEMaddr  out  32  rs1+imm.
EX_MEMrden  out  4  read byte lanes.
EX_MEMrden_SEXT  out  1  sign-extend load.
EX_MEMwren  out  4  write byte lanes.
EX_MEMwrdata  out  32  store data, lane-replicated.
EX_busy  out  1  MDU iterating.

Behaviour:
- Reset: every output 0 except inst_rdy=1. State IDLE; MDU counters and accumulators cleared.
- Pulse outputs (EX_jmp_vld, EX_x_rd_vld, EX_MEMrden, EX_MEMwren, EX_MEMrden_SEXT) default to 0 each cycle and are high for exactly one cycle per instruction. Data outputs hold their value when not updated.
- inst_rdy = (state==IDLE) | (state==DONE).
- Accept = inst_vld & inst_rdy & ~flush.
- Single-cycle ops: outputs register on the accept edge, giving latency 1.
  - Arithmetic/logic: ADD/SUB/AND/OR/XOR and the immediate forms.
  - Shifts: amount = operand[4:0]. SRA/SRAI are arithmetic shifts.
  - SLT/SLTI are signed compares; SLTU/SLTIU are unsigned. Result is 0 or 1.
  - Branches: EX_jmp_vld = condition, EX_jmp_addr = pc+imm.
  - JAL: rd=pc+4 only. JALR: jump to (rs1+imm)&~1, and rd=pc+4.
  - LUI/AUIPC: rd = imm / pc+imm.
  - Loads: lane selection from addr[1:0].
- Stores:
  - SW: wren 1111, data rs2.
  - SH: wren 1100 if addr[1], else 0011; data {2{rs2[15:0]}}.
  - SB: wren = 0001<<addr[1:0]; data {4{rs2[7:0]}}.
  - Misaligned addresses are not trapped; lanes come from the low bits only.
- MDU states: IDLE -> MUL | DIV -> DONE -> IDLE (or straight to MUL/DIV on a back-to-back accept).
  - MUL: iterative path has 32 iterations, one partial product per cycle over a 64-bit accumulator. MULHSU and MULH use signed operands: magnitudes are multiplied, then the 64-bit product is negated if the signs differ.
  - MUL returns product[31:0]. The MULH variants return product[63:32].
  - DIV: restoring division on magnitudes, 32/DIV_STEP iterations. Quotient is negated if signs differ (DIV). Remainder takes the sign of the dividend (REM).
  - Latency: accept on edge T; EX_x_rd_vld is high in the cycle following edge T+N+1 (N = iteration count), i.e. state DONE.
  - EX_busy is high from T until DONE.
- Early-out cases complete single-cycle, with no busy period:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (0x80000000 / -1): DIV returns 0x80000000; REM returns 0.
  - FAST_MUL=1: all multiplies are single-cycle.
- Flush:
  - Aborts MUL/DIV to IDLE with no EX_x_rd_vld.
  - An instruction offered in the same cycle is dropped.
  - Flush in DONE does not cancel the already-registered pulse.
  - Flush in IDLE has no effect beyond dropping the offer.
- Reset asserted mid-operation returns everything to reset values immediately.
- With inst_vld high and inst_rdy low, the instruction is not consumed. Decode must hold its inputs stable until accepted.

Test Plan:
- ADD then SRA back-to-back: rs1=0xF0000000, rs2=4 -> rd 0xF0000004, then 0xFF000000 on consecutive cycles, each with a one-cycle vld.
- SH at addr 0x102, rs2=0x1234ABCD -> wren 1100, wrdata 0xABCDABCD. SB at 0x103 -> wren 1000, wrdata 0xCDCDCDCD.
- MULH, FAST_MUL=0, rs1=0xFFFFFFFE, rs2=3 -> inst_rdy low for 33 cycles, then rd=0xFFFFFFFF. MULHU with the same operands -> 0x00000002.
- DIV, DIV_STEP=2, rs1=-7, rs2=2 -> rd=0xFFFFFFFD after 17 cycles. REM with the same operands -> 0xFFFFFFFF.
- DIVU by 0 -> rd=0xFFFFFFFF next cycle, EX_busy never high. DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- DIV accepted, flush at iteration 5 with a BEQ offered in the same cycle -> no vld, BEQ dropped, inst_rdy=1 next cycle. Also assert rst_n low during MUL -> all outputs 0, inst_rdy=1.

Source files
------------

// File: rtl/execute_mdu.sv
// RV32IM execute stage: single-cycle ALU/branch/load/store plus an iterative multiply/divide unit.
// Latency: 1 cycle for single-cycle ops and MDU early-outs; N+1 cycles for MDU ops (N = 32 mul, 32/DIV_STEP div).
// Backpressure: inst_rdy drops while the MDU iterates; flush aborts the MDU op and drops the offered instruction.
// Ports: clk/rst_n; decode side inst_vld/inst_rdy/flush, x_rs1/x_rs2/imm/instID/pc;
//        EX_* side: jump pulse+target, rd pulse+value, memory address/lanes/store data, EX_busy.
module execute_mdu #(
   parameter int ID_W     = 6,
   parameter int FAST_MUL = 0,
   parameter int DIV_STEP = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inst_vld,
   output logic            inst_rdy,
   input  logic            flush,
   input  logic [31:0]     x_rs1,
   input  logic [31:0]     x_rs2,
   input  logic [31:0]     imm,
   input  logic [ID_W-1:0] instID,
   input  logic [31:0]     pc,
   output logic            EX_jmp_vld,
   output logic [31:0]     EX_jmp_addr,
   output logic            EX_x_rd_vld,
   output logic [31:0]     EX_x_rd,
   output logic [31:0]     EX_MEMaddr,
   output logic [3:0]      EX_MEMrden,
   output logic            EX_MEMrden_SEXT,
   output logic [3:0]      EX_MEMwren,
   output logic [31:0]     EX_MEMwrdata,
   output logic            EX_busy
);
   // Instruction IDs
   localparam logic [ID_W-1:0] ID_ADD = 1, ID_ADDI = 2, ID_SUB = 3, ID_AND = 4, ID_ANDI = 5,
      ID_OR = 6, ID_ORI = 7, ID_XOR = 8, ID_XORI = 9, ID_SLL = 10, ID_SLLI = 11, ID_SRL = 12,
      ID_SRLI = 13, ID_SRA = 14, ID_SRAI = 15, ID_SLT = 16, ID_SLTI = 17, ID_SLTU = 18,
      ID_SLTIU = 19, ID_LUI = 20, ID_AUIPC = 21, ID_JAL = 22, ID_JALR = 23, ID_BEQ = 24,
      ID_BNE = 25, ID_BLT = 26, ID_BGE = 27, ID_BLTU = 28, ID_BGEU = 29, ID_LB = 30, ID_LH = 31,
      ID_LW = 32, ID_LBU = 33, ID_LHU = 34, ID_SB = 35, ID_SH = 36, ID_SW = 37, ID_MUL = 38,
      ID_MULH = 39, ID_MULHSU = 40, ID_MULHU = 41, ID_DIV = 42, ID_DIVU = 43, ID_REM = 44,
      ID_REMU = 45;
   localparam logic [5:0] MUL_N = 6'd32;
   localparam logic [5:0] DIV_N = 6'(32 / DIV_STEP);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
   state_t state, state_nxt;

   logic        accept, start_mul, start_div;
   logic [31:0] maddr;
   logic        sgn_a, sgn_b, a_neg, b_neg, is_rem, div_zero, div_ovf;
   logic [31:0] a_mag, b_mag;
   logic [63:0] fast_p, mul_p;
   logic [63:0] opa, acc;
   logic [31:0] opb, mul_res, div_res, div_r, div_q;
   logic [32:0] div_t;
   logic [5:0]  cnt;
   logic        mdu_neg, mdu_neg_r, mdu_sel;
   logic        mul_fin, div_fin;

   logic        sc_wr, sc_jmp, sc_jupd, sc_mupd, sc_sext;
   logic [31:0] sc_rd, sc_jaddr, sc_wdata;
   logic [3:0]  sc_rden, sc_wren;

   assign inst_rdy = (state == S_IDLE) | (state == S_DONE);
   assign accept   = inst_vld & inst_rdy & ~flush;
   assign EX_busy  = (state == S_MUL) | (state == S_DIV);
   assign maddr    = x_rs1 + imm;

   // Operand conditioning: the MDU always works on magnitudes and fixes signs at the end
   assign sgn_a    = (instID == ID_MULH) | (instID == ID_MULHSU) | (instID == ID_DIV) | (instID == ID_REM);
   assign sgn_b    = (instID == ID_MULH) | (instID == ID_DIV) | (instID == ID_REM);
   assign a_neg    = sgn_a & x_rs1[31];
   assign b_neg    = sgn_b & x_rs2[31];
   assign a_mag    = a_neg ? 32'd0 - x_rs1 : x_rs1;
   assign b_mag    = b_neg ? 32'd0 - x_rs2 : x_rs2;
   assign is_rem   = (instID == ID_REM) | (instID == ID_REMU);
   assign div_zero = (x_rs2 == 32'd0);
   assign div_ovf  = ((instID == ID_DIV) | (instID == ID_REM)) &
                     (x_rs1 == 32'h8000_0000) & (x_rs2 == 32'hFFFF_FFFF);

   assign fast_p   = (a_neg ^ b_neg) ? 64'd0 - ({32'd0, a_mag} * {32'd0, b_mag})
                                     : {32'd0, a_mag} * {32'd0, b_mag};

   // Final result selection once iterations complete
   assign mul_p    = mdu_neg ? 64'd0 - acc : acc;
   assign mul_res  = mdu_sel ? mul_p[63:32] : mul_p[31:0];
   assign div_res  = mdu_sel ? (mdu_neg_r ? 32'd0 - acc[63:32] : acc[63:32])
                             : (mdu_neg   ? 32'd0 - acc[31:0]  : acc[31:0]);
   assign mul_fin  = (state == S_MUL) & ~flush & (cnt == MUL_N);
   assign div_fin  = (state == S_DIV) & ~flush & (cnt == DIV_N);

   // Restoring division, DIV_STEP quotient bits per cycle; acc = {remainder, dividend/quotient}
   always_comb begin
      div_r = acc[63:32];
      div_q = acc[31:0];
      div_t = '0;
      for (int i = 0; i < DIV_STEP; i++) begin
         div_t = {div_r, div_q[31]};
         div_q = {div_q[30:0], 1'b0};
         if (div_t >= {1'b0, opb}) begin
            div_t    = div_t - {1'b0, opb};
            div_q[0] = 1'b1;
         end
         div_r = div_t[31:0];
      end
   end

   // Single-cycle decode/execute
   always_comb begin
      sc_wr = 1'b0; sc_rd = '0; sc_jmp = 1'b0; sc_jupd = 1'b0; sc_jaddr = pc + imm;
      sc_mupd = 1'b0; sc_rden = '0; sc_sext = 1'b0; sc_wren = '0; sc_wdata = x_rs2;
      start_mul = 1'b0; start_div = 1'b0;
      case (instID)
         ID_ADD:   begin sc_wr = 1'b1; sc_rd = x_rs1 + x_rs2; end
         ID_ADDI:  begin sc_wr = 1'b1; sc_rd = x_rs1 + imm; end
         ID_SUB:   begin sc_wr = 1'b1; sc_rd = x_rs1 - x_rs2; end
         ID_AND:   begin sc_wr = 1'b1; sc_rd = x_rs1 & x_rs2; end
         ID_ANDI:  begin sc_wr = 1'b1; sc_rd = x_rs1 & imm; end
         ID_OR:    begin sc_wr = 1'b1; sc_rd = x_rs1 | x_rs2; end
         ID_ORI:   begin sc_wr = 1'b1; sc_rd = x_rs1 | imm; end
         ID_XOR:   begin sc_wr = 1'b1; sc_rd = x_rs1 ^ x_rs2; end
         ID_XORI:  begin sc_wr = 1'b1; sc_rd = x_rs1 ^ imm; end
         ID_SLL:   begin sc_wr = 1'b1; sc_rd = x_rs1 << x_rs2[4:0]; end
         ID_SLLI:  begin sc_wr = 1'b1; sc_rd = x_rs1 << imm[4:0]; end
         ID_SRL:   begin sc_wr = 1'b1; sc_rd = x_rs1 >> x_rs2[4:0]; end
         ID_SRLI:  begin sc_wr = 1'b1; sc_rd = x_rs1 >> imm[4:0]; end
         ID_SRA:   begin sc_wr = 1'b1; sc_rd = $signed(x_rs1) >>> x_rs2[4:0]; end
         ID_SRAI:  begin sc_wr = 1'b1; sc_rd = $signed(x_rs1) >>> imm[4:0]; end
         ID_SLT:   begin sc_wr = 1'b1; sc_rd = {31'd0, $signed(x_rs1) < $signed(x_rs2)}; end
         ID_SLTI:  begin sc_wr = 1'b1; sc_rd = {31'd0, $signed(x_rs1) < $signed(imm)}; end
         ID_SLTU:  begin sc_wr = 1'b1; sc_rd = {31'd0, x_rs1 < x_rs2}; end
         ID_SLTIU: begin sc_wr = 1'b1; sc_rd = {31'd0, x_rs1 < imm}; end
         ID_LUI:   begin sc_wr = 1'b1; sc_rd = imm; end
         ID_AUIPC: begin sc_wr = 1'b1; sc_rd = pc + imm; end
         ID_JAL:   begin sc_wr = 1'b1; sc_rd = pc + 32'd4; end
         ID_JALR:  begin
            sc_wr = 1'b1; sc_rd = pc + 32'd4;
            sc_jmp = 1'b1; sc_jupd = 1'b1; sc_jaddr = maddr & ~32'd1;
         end
         ID_BEQ:   begin sc_jupd = 1'b1; sc_jmp = (x_rs1 == x_rs2); end
         ID_BNE:   begin sc_jupd = 1'b1; sc_jmp = (x_rs1 != x_rs2); end
         ID_BLT:   begin sc_jupd = 1'b1; sc_jmp = ($signed(x_rs1) <  $signed(x_rs2)); end
         ID_BGE:   begin sc_jupd = 1'b1; sc_jmp = ($signed(x_rs1) >= $signed(x_rs2)); end
         ID_BLTU:  begin sc_jupd = 1'b1; sc_jmp = (x_rs1 <  x_rs2); end
         ID_BGEU:  begin sc_jupd = 1'b1; sc_jmp = (x_rs1 >= x_rs2); end
         ID_LB, ID_LBU: begin
            sc_mupd = 1'b1; sc_rden = 4'b0001 << maddr[1:0]; sc_sext = (instID == ID_LB);
         end
         ID_LH, ID_LHU: begin
            sc_mupd = 1'b1; sc_rden = maddr[1] ? 4'b1100 : 4'b0011; sc_sext = (instID == ID_LH);
         end
         ID_LW:    begin sc_mupd = 1'b1; sc_rden = 4'b1111; end
         ID_SB:    begin sc_mupd = 1'b1; sc_wren = 4'b0001 << maddr[1:0]; sc_wdata = {4{x_rs2[7:0]}}; end
         ID_SH:    begin
            sc_mupd = 1'b1; sc_wren = maddr[1] ? 4'b1100 : 4'b0011; sc_wdata = {2{x_rs2[15:0]}};
         end
         ID_SW:    begin sc_mupd = 1'b1; sc_wren = 4'b1111; end
         ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU: begin
            if (FAST_MUL != 0) begin
               sc_wr = 1'b1;
               sc_rd = (instID == ID_MUL) ? fast_p[31:0] : fast_p[63:32];
            end else begin
               start_mul = 1'b1;
            end
         end
         ID_DIV, ID_DIVU, ID_REM, ID_REMU: begin
            if (div_zero) begin
               sc_wr = 1'b1; sc_rd = is_rem ? x_rs1 : 32'hFFFF_FFFF;
            end else if (div_ovf) begin
               sc_wr = 1'b1; sc_rd = is_rem ? 32'd0 : 32'h8000_0000;
            end else begin
               start_div = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            state_nxt = S_IDLE;
            if (accept & start_mul)      state_nxt = S_MUL;
            else if (accept & start_div) state_nxt = S_DIV;
         end
         S_MUL: if (flush) state_nxt = S_IDLE; else if (cnt == MUL_N) state_nxt = S_DONE;
         S_DIV: if (flush) state_nxt = S_IDLE; else if (cnt == DIV_N) state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // MDU operand/accumulator registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0; opa <= '0; opb <= '0; acc <= '0;
         mdu_neg <= 1'b0; mdu_neg_r <= 1'b0; mdu_sel <= 1'b0;
      end else if (accept & (start_mul | start_div)) begin
         cnt       <= '0;
         opb       <= b_mag;
         mdu_neg   <= a_neg ^ b_neg;
         mdu_neg_r <= a_neg;
         mdu_sel   <= start_mul ? (instID != ID_MUL) : is_rem;
         opa       <= start_mul ? {32'd0, a_mag} : 64'd0;
         acc       <= start_mul ? 64'd0 : {32'd0, a_mag};
      end else if (state == S_MUL) begin
         cnt <= cnt + 6'd1;
         if (opb[0]) acc <= acc + opa;
         opa <= opa << 1;
         opb <= opb >> 1;
      end else if (state == S_DIV) begin
         cnt <= cnt + 6'd1;
         acc <= {div_r, div_q};
      end
   end

   // Output registers: pulses clear every cycle, data holds until rewritten
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         EX_jmp_vld <= 1'b0; EX_jmp_addr <= '0; EX_x_rd_vld <= 1'b0; EX_x_rd <= '0;
         EX_MEMaddr <= '0; EX_MEMrden <= '0; EX_MEMrden_SEXT <= 1'b0;
         EX_MEMwren <= '0; EX_MEMwrdata <= '0;
      end else begin
         EX_jmp_vld <= 1'b0; EX_x_rd_vld <= 1'b0;
         EX_MEMrden <= '0; EX_MEMrden_SEXT <= 1'b0; EX_MEMwren <= '0;
         if (accept) begin
            EX_jmp_vld      <= sc_jmp;
            EX_x_rd_vld     <= sc_wr;
            EX_MEMrden      <= sc_rden;
            EX_MEMrden_SEXT <= sc_sext;
            EX_MEMwren      <= sc_wren;
            if (sc_jupd)          EX_jmp_addr  <= sc_jaddr;
            if (sc_wr)            EX_x_rd      <= sc_rd;
            if (sc_mupd)          EX_MEMaddr   <= maddr;
            if (sc_wren != 4'd0)  EX_MEMwrdata <= sc_wdata;
         end else if (mul_fin) begin
            EX_x_rd_vld <= 1'b1;
            EX_x_rd     <= mul_res;
         end else if (div_fin) begin
            EX_x_rd_vld <= 1'b1;
            EX_x_rd     <= div_res;
         end
      end
   end
endmodule
